data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares one byte-wide, synchronous-read data memory between two word-oriented requesters: the core load/store path (port `c_`) and the program/debug loader (port `l_`). Arbitration is round-robin. Each granted word access is split into four little-endian byte beats, and the result is returned with a one-cycle completion pulse. The block sits between the datapath and the data memory array, replacing direct combinational access to the array.

## Interface
Parameters:
- `ADDR_W`, default 10: byte-address width of the memory (1024 bytes). Requester addresses are truncated to `ADDR_W` bits.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `c_req`  in  1  core request; held high until `c_gnt`.
- `c_we`  in  1  core write enable (1 = store, 0 = load).
- `c_addr`  in  32  core byte address.
- `c_wdata`  in  32  core store data.
- `c_gnt`  out  1  core request accepted this cycle.
- `c_done`  out  1  one-cycle pulse: core transaction complete.
- `c_rdata`  out  32  core load result; valid when `c_done`=1 for a read.
- `l_req`, `l_we`, `l_addr`[32], `l_wdata`[32]  in: loader request, same semantics as the core port.
- `l_gnt`, `l_done`  out  1 each: loader grant and completion, same semantics as the core port.
- `l_rdata`  out  32: loader load result, same semantics as `c_rdata`.
- `m_en`  out  1  memory beat enable.
- `m_we`  out  1  memory byte write.
- `m_addr`  out  `ADDR_W`  memory byte address.
- `m_wdata`  out  8  memory write byte.
- `m_rdata`  in  8  memory read byte; valid the cycle after a read beat.

## Operation
- FSM states:
  - IDLE: accept a request.
  - BEAT: issue four byte beats, counter `k` = 0..3.
  - DRAIN: capture the last read byte.
  - RESP: pulse the completion signal.
- IDLE:
  - If any request is high, assert the winner's `gnt` combinationally.
  - At that edge, latch `we`, `addr[ADDR_W-1:0]`, `wdata` and the owner; go to BEAT with `k`=0.
  - With no request, stay in IDLE.
- Arbitration:
  - If one requester is active, it wins.
  - If both are active, the requester not granted last wins.
  - The last-granted pointer resets to loader, so the core wins the first tie.
- BEAT:
  - Drive `m_en`=1, `m_we`=latched we, `m_addr`=(addr+k) mod 2^ADDR_W, `m_wdata`=wdata[8k+7:8k].
  - After `k`=3, go to DRAIN.
- Read assembly: the byte returned for beat k is written to rdata[8k+7:8k] at the end of the following cycle.
- DRAIN: `m_en`=0; captures byte 3; go to RESP.
- RESP:
  - Pulse the owner's `done`; return to IDLE.
  - Writes also pass through DRAIN and RESP, so write and read latency are equal.
- Read data:
  - `c_rdata` and `l_rdata` are both driven from one shared rdata register.
  - The register holds its value until the next read completes; it is unchanged by writes.
- Request handling:
  - Changes to `req`, `addr`, `we` or `wdata` after grant are ignored.
  - A request that drops before being granted is never served.
- Alignment: addresses need no alignment. Beats wrap modulo 2^ADDR_W, so 0x3FE produces beats 0x3FE, 0x3FF, 0x000, 0x001.

## Timing
- Reset values: state IDLE; `c_gnt`, `l_gnt`, `c_done`, `l_done`, `m_en`, `m_we` = 0; `m_addr` = 0; `m_wdata` = 0; rdata = 0.
- Latency, with grant in cycle 0:
  - Beats in cycles 1–4.
  - DRAIN in cycle 5.
  - `done` in cycle 6.
  - Earliest next grant in cycle 7.
- Throughput: one word per 7 cycles.
- `gnt` asserts only in IDLE and never for both requesters in the same cycle.
- `done` asserts for exactly one cycle per grant, on the owner's port only.
- A requester that holds `req` high across its own `done` is re-arbitrated in cycle 7. If the other requester is also waiting, the other requester wins.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately (asynchronously) and the transaction is dropped with no `done`.
  - Bytes already written stay in memory.
  - The arbitration pointer resets.

## Test plan
- Memory preloaded with mem[i]=i. Core read at 0x010 → `c_gnt` in cycle 0, `m_addr` 0x010–0x013 in cycles 1–4, `c_done` in cycle 6 with `c_rdata`=0x13121110, `l_done` stays 0.
- Loader write 0xDEADBEEF at 0x3FE → bytes 0x3FE=EF, 0x3FF=BE, 0x000=AD, 0x001=DE; `l_done` in cycle 6; rdata unchanged.
- Both requesters high after reset, held continuously → grant order core, loader, core, loader, with grants in cycles 0, 7, 14, 21.
- Core requests in cycle 2 of a loader transaction → `c_gnt` in the loader's cycle 7; no `c_gnt` earlier.
- Write 0x11223344 at 0x020 with `rst` pulsed in cycle 3 → `m_en`=0 immediately, no `done`; mem[0x020]=0x44, mem[0x021]=0x33, mem[0x022..0x023] unchanged.
- Core read at 0x004, then core write at 0x004 → after the write, `c_rdata` still 0x07060504.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two word requester ports and the byte-wide memory port.
// Handshake: req is held high until gnt; gnt completes acceptance in that cycle; done pulses once per grant.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              c_req;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic              c_gnt;
    logic              c_done;
    logic [31:0]       c_rdata;

    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_done;
    logic [31:0]       l_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;

    // Requesters and the memory array sit on the master side.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_done, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_done, l_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_done, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_done, l_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving the core and loader word access to a byte-wide
// synchronous-read memory, as four little-endian byte beats per word.
module data_mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic              owner_q, owner_d;   // 0 = core, 1 = loader
    logic              last_q, last_d;     // last granted requester
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              c_done_q, c_done_d;
    logic              l_done_q, l_done_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [7:0]        m_wdata_q, m_wdata_d;

    logic              any_req;
    logic              win_l;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        k_nxt;
    logic [1:0]        k_prev;
    logic              unused_addr_hi;

    // On a tie the requester not granted last wins.
    assign any_req   = bus.c_req | bus.l_req;
    assign win_l     = bus.l_req & (~bus.c_req | ~last_q);
    assign sel_we    = win_l ? bus.l_we    : bus.c_we;
    assign sel_addr  = win_l ? bus.l_addr  : bus.c_addr;
    assign sel_wdata = win_l ? bus.l_wdata : bus.c_wdata;
    assign k_nxt     = k_q + 2'd1;
    assign k_prev    = k_q - 2'd1;
    assign unused_addr_hi = ^{bus.c_addr[31:ADDR_W], bus.l_addr[31:ADDR_W]};

    assign bus.c_gnt = (state_q == S_IDLE) & any_req & ~win_l;
    assign bus.l_gnt = (state_q == S_IDLE) & win_l;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        c_done_d  = 1'b0;
        l_done_d  = 1'b0;
        m_en_d    = m_en_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d   = win_l;
                    last_d    = win_l;
                    we_d      = sel_we;
                    addr_d    = sel_addr[ADDR_W-1:0];
                    wdata_d   = sel_wdata;
                    k_d       = 2'd0;
                    state_d   = S_BEAT;
                    m_en_d    = 1'b1;
                    m_we_d    = sel_we;
                    m_addr_d  = sel_addr[ADDR_W-1:0];
                    m_wdata_d = sel_wdata[7:0];
                end
            end
            S_BEAT: begin
                // The byte for beat k-1 arrives while beat k is on the bus.
                if (!we_q && k_q != 2'd0) begin
                    rdata_d[{k_prev, 3'b000} +: 8] = bus.m_rdata;
                end
                if (k_q == 2'd3) begin
                    state_d = S_DRAIN;
                    m_en_d  = 1'b0;
                    m_we_d  = 1'b0;
                end else begin
                    k_d       = k_nxt;
                    m_addr_d  = addr_q + ADDR_W'(k_nxt);
                    m_wdata_d = wdata_q[{k_nxt, 3'b000} +: 8];
                end
            end
            S_DRAIN: begin
                if (!we_q) begin
                    rdata_d[31:24] = bus.m_rdata;
                end
                c_done_d = ~owner_q;
                l_done_d = owner_q;
                state_d  = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            c_done_q  <= 1'b0;
            l_done_q  <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            c_done_q  <= c_done_d;
            l_done_q  <= l_done_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign bus.c_done  = c_done_q;
    assign bus.l_done  = l_done_q;
    assign bus.c_rdata = rdata_q;
    assign bus.l_rdata = rdata_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign dbg_state   = state_q;
endmodule
